dual_port_ram_param: RTL and testbench
======================================

// Module: dual_port_ram_param
// PURPOSE
//   Parametrised true dual-port synchronous RAM: two independent ports, A and B, on one clock.
//   Adds registered reads with a read-valid strobe and a deterministic write-write collision policy.
//   A post-reset clear sequencer zeroes the array before the first access is accepted.
//   Memory leaf for buffer and scratchpad users; successor to the fixed 16x8 dual-port RAM.
// PARAMETERS
//   ADDR_W    4   address width; DEPTH = 2**ADDR_W words
//   DATA_W    8   word width in bits
//   PRIORITY  0   same-address write-write winner: 0 = port A, 1 = port B
// PORTS
//   clk        in   1       single clock; all activity on rising edge
//   rst_n      in   1       synchronous reset, active low
//   cs         in   1       chip select, active low (1 = both ports idle)
//   wr_rd_a    in   1       port A: 1 = write, 0 = read
//   addr_a     in   ADDR_W  port A address
//   wdata_a    in   DATA_W  port A write data
//   rdata_a    out  DATA_W  port A registered read data
//   rvalid_a   out  1       port A read-data-valid strobe, 1 cycle
//   wr_rd_b    in   1       port B: 1 = write, 0 = read
//   addr_b     in   ADDR_W  port B address
//   wdata_b    in   DATA_W  port B write data
//   rdata_b    out  DATA_W  port B registered read data
//   rvalid_b   out  1       port B read-data-valid strobe, 1 cycle
//   collision  out  1       pulse: same-address write-write occurred
//   init_done  out  1       1 = clear finished; ports are live
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - rdata_a/b=0, rvalid_a/b=0, collision=0, init_done=0.
//     - FSM state goes to CLEAR; clear counter = 0.
//     - Reset applied mid-CLEAR or mid-READY aborts the current operation and restarts the clear.
//   FSM CLEAR: each edge writes 0 to mem[cnt] and increments cnt.
//     - Port inputs and cs are ignored; rvalid stays 0.
//     - On the edge that writes address DEPTH-1: state goes to READY and init_done goes to 1.
//     - The first port access is accepted on the next edge, i.e. DEPTH edges after reset release.
//   FSM READY: stays READY until reset. Ports are sampled only when cs=0.
//     - Write (wr_rd=1): mem[addr] <= wdata at the edge.
//     - Read (wr_rd=0): rdata <= mem[addr] at the edge. Latency 1: data is visible after the
//       sampling edge. rvalid=1 for exactly that cycle.
//     - Idle (cs=1, or state is CLEAR): rdata holds its last value; rvalid=0.
//   Read-during-write (one port reads, the other writes the same address, same edge):
//     the read returns the OLD word. The array is updated normally. collision stays 0.
//   Write-write to the same address (same edge):
//     - Only the PRIORITY port's data is stored.
//     - collision=1 for one cycle, after that edge.
//     - Writes to different addresses on the same edge both complete; collision stays 0.
//   A port reading its own write address on the same edge is impossible (wr_rd is 1 bit).
//   Address and data are unsigned. No wrap logic: addr covers exactly DEPTH words.
// CONFIGURATION
//   DPR_OUT_REG_EN defined: adds a second output register per port.
//     - Read latency becomes 2. rvalid is delayed with its data.
//     - The extra stage resets to 0 and holds when no read is in flight.
//     - A reset mid-pipeline drops in-flight reads.
//   DPR_OUT_REG_EN undefined: latency 1 as above; no extra registers.
// TESTING (ADDR_W=4, DATA_W=8 unless noted)
//   1. Hold rst_n=0 for 2 edges, then release.
//      -> init_done=0 for 15 edges and 1 after the 16th.
//      -> Reading A at addr 0..15 returns 0x00 for every address.
//   2. Reset 5 edges into CLEAR.
//      -> init_done stays 0; counter restarts; init_done rises 16 edges after the new release.
//   3. cs=1 with A writing addr 3 = 0xAA; then cs=0, B reads addr 3.
//      -> rdata_b=0x00; rvalid_b is 0 while cs=1.
//   4. A writes addr 5 = 0x3C; next edge B reads addr 5.
//      -> rdata_b=0x3C and rvalid_b=1 for one cycle after that edge.
//      -> With DPR_OUT_REG_EN: same values one cycle later.
//   5. Set mem[7]=0x22; then on the same edge A writes 7 = 0x11 and B reads 7.
//      -> rdata_b=0x22; a later read of addr 7 returns 0x11.
//   6. On the same edge A writes 5 = 77 and B writes 5 = 98.
//      -> PRIORITY=0: mem[5]=77. PRIORITY=1: mem[5]=98.
//      -> collision=1 for exactly one cycle in both cases.
//      -> Writing addr 4 and addr 6 together gives collision=0 and stores both words.

Source files
------------

// File: rtl/dual_port_ram_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_param
// Purpose  : Parametrised true dual-port synchronous RAM (ports A and B, one
//            clock) with registered reads, a one-cycle read-valid strobe, a
//            deterministic same-address write-write policy and a post-reset
//            clear sequencer that zeroes the array before ports go live.
// Ports    : clk            - single clock, rising edge
//            rst_n          - synchronous reset, active low
//            cs             - chip select, active low (1 = both ports idle)
//            wr_rd_a/b      - 1 = write, 0 = read
//            addr_a/b       - word address (ADDR_W bits)
//            wdata_a/b      - write data (DATA_W bits)
//            rdata_a/b      - registered read data
//            rvalid_a/b     - read data valid, one cycle per read
//            collision      - one-cycle pulse after a same-address double write
//            init_done      - 1 once the clear sequence has finished
// Params   : ADDR_W (4), DATA_W (8), PRIORITY (0 = port A wins, 1 = port B)
// Config   : DPR_OUT_REG_EN - adds a second output register per port
//            (read latency 2, rvalid delayed with its data)
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_ram_param #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              wr_rd_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              wr_rd_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              collision,
    output logic              init_done
);

    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;
    localparam logic            C_B_WINS  = (PRIORITY != 0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                w_clear_we;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_live;
    logic                w_we_a_req;
    logic                w_we_b_req;
    logic                w_same_wr;
    logic                w_we_a;
    logic                w_we_b;
    logic                w_rd_a;
    logic                w_rd_b;

    logic [DATA_W-1:0]   r_rdata_a;
    logic [DATA_W-1:0]   r_rdata_b;
    logic                r_rvalid_a;
    logic                r_rvalid_b;
    logic                r_collision;

    // ------------------------------------------------------------------
    // Clear / ready sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clear_we  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clear_we = 1'b1;
                w_cnt_nxt  = r_cnt + 1'b1;
                if (r_cnt == C_LAST_ADDR) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    assign init_done = (r_state == ST_READY);

    // ------------------------------------------------------------------
    // Port decode; a same-address double write keeps only the winner
    // ------------------------------------------------------------------
    assign w_live     = (r_state == ST_READY) && !cs;
    assign w_we_a_req = w_live &&  wr_rd_a;
    assign w_we_b_req = w_live &&  wr_rd_b;
    assign w_rd_a     = w_live && !wr_rd_a;
    assign w_rd_b     = w_live && !wr_rd_b;
    assign w_same_wr  = w_we_a_req && w_we_b_req && (addr_a == addr_b);
    assign w_we_a     = w_we_a_req && !(w_same_wr &&  C_B_WINS);
    assign w_we_b     = w_we_b_req && !(w_same_wr && !C_B_WINS);

    // ------------------------------------------------------------------
    // Storage array; no write on a reset edge so a reset simply restarts
    // the clear from address 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clear_we) begin
                r_mem[r_cnt] <= '0;
            end else begin
                if (w_we_a) begin
                    r_mem[addr_a] <= wdata_a;
                end
                if (w_we_b) begin
                    r_mem[addr_b] <= wdata_b;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered reads: non-blocking semantics give the old word when the
    // other port writes the same address on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata_a   <= '0;
            r_rdata_b   <= '0;
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_rvalid_a  <= w_rd_a;
            r_rvalid_b  <= w_rd_b;
            r_collision <= w_same_wr;
            if (w_rd_a) begin
                r_rdata_a <= r_mem[addr_a];
            end
            if (w_rd_b) begin
                r_rdata_b <= r_mem[addr_b];
            end
        end
    end

    assign collision = r_collision;

`ifdef DPR_OUT_REG_EN
    // Second output stage: advances only when a read is in flight so the
    // last returned word is held on the outputs.
    logic [DATA_W-1:0] r_rdata_a_q;
    logic [DATA_W-1:0] r_rdata_b_q;
    logic              r_rvalid_a_q;
    logic              r_rvalid_b_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata_a_q  <= '0;
            r_rdata_b_q  <= '0;
            r_rvalid_a_q <= 1'b0;
            r_rvalid_b_q <= 1'b0;
        end else begin
            r_rvalid_a_q <= r_rvalid_a;
            r_rvalid_b_q <= r_rvalid_b;
            if (r_rvalid_a) begin
                r_rdata_a_q <= r_rdata_a;
            end
            if (r_rvalid_b) begin
                r_rdata_b_q <= r_rdata_b;
            end
        end
    end

    assign rdata_a  = r_rdata_a_q;
    assign rdata_b  = r_rdata_b_q;
    assign rvalid_a = r_rvalid_a_q;
    assign rvalid_b = r_rvalid_b_q;
`else
    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_ram_param
// Purpose  : Directed self-checking bench for dual_port_ram_param. Two
//            instances share all inputs: u_dut0 (PRIORITY=0) and u_dut1
//            (PRIORITY=1). Inputs change and outputs are sampled on the
//            falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_param;

`ifdef DPR_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       wr_rd_a;
    logic [3:0] addr_a;
    logic [7:0] wdata_a;
    logic       wr_rd_b;
    logic [3:0] addr_b;
    logic [7:0] wdata_b;

    logic [7:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic       rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
    logic       collision0, collision1;
    logic       init_done0, init_done1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dual_port_ram_param #(.ADDR_W(4), .DATA_W(8), .PRIORITY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cs(cs),
        .wr_rd_a(wr_rd_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
        .wr_rd_b(wr_rd_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
        .collision(collision0), .init_done(init_done0)
    );

    dual_port_ram_param #(.ADDR_W(4), .DATA_W(8), .PRIORITY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cs(cs),
        .wr_rd_a(wr_rd_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
        .wr_rd_b(wr_rd_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
        .collision(collision1), .init_done(init_done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        cs      = 1'b1;
        wr_rd_a = 1'b0;
        wr_rd_b = 1'b0;
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b0; wr_rd_a = 1'b1; addr_a = a; wdata_a = d; wr_rd_b = 1'b0;
        step();
        set_idle();
    endtask

    // Both ports read; returns once data is visible on the outputs.
    task automatic rd(input logic [3:0] aa, input logic [3:0] ab);
        cs = 1'b0; wr_rd_a = 1'b0; wr_rd_b = 1'b0; addr_a = aa; addr_b = ab;
        step();
        set_idle();
        repeat (LAT - 1) step();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        do_reset(2);
        total_cnt++; if (rdata_a0 !== 8'h00) $display("FAIL reset_rdata_a got=%h exp=%h", rdata_a0, 8'h00); else pass_cnt++;
        total_cnt++; if (rdata_b0 !== 8'h00) $display("FAIL reset_rdata_b got=%h exp=%h", rdata_b0, 8'h00); else pass_cnt++;
        total_cnt++; if (rvalid_a0 !== 1'b0) $display("FAIL reset_rvalid_a got=%b exp=0", rvalid_a0); else pass_cnt++;
        total_cnt++; if (collision0 !== 1'b0) $display("FAIL reset_collision got=%b exp=0", collision0); else pass_cnt++;
        total_cnt++; if (init_done0 !== 1'b0) $display("FAIL reset_init_done got=%b exp=0", init_done0); else pass_cnt++;
        for (int i = 1; i <= 16; i++) begin
            step();
            total_cnt++;
            if (init_done0 !== (i == 16)) $display("FAIL init_timing edge=%0d got=%b exp=%b", i, init_done0, (i == 16));
            else pass_cnt++;
        end
    endtask

    // Fill with non-zero data, reset, then every word must read back zero.
    task automatic test_clear_zeroes();
        for (int i = 0; i < 16; i++) wr_a(i[3:0], 8'hA0 + i[7:0]);
        rd(4'd9, 4'd9);
        total_cnt++; if (rdata_a0 !== 8'hA9) $display("FAIL fill_readback got=%h exp=%h", rdata_a0, 8'hA9); else pass_cnt++;
        do_reset(1);
        repeat (16) step();
        for (int i = 0; i < 16; i++) begin
            rd(i[3:0], 4'd15 - i[3:0]);
            total_cnt++;
            if (rdata_a0 !== 8'h00 || rdata_b0 !== 8'h00 || rvalid_a0 !== 1'b1)
                $display("FAIL clear_read addr=%0d got a=%h b=%h v=%b exp a=00 b=00 v=1", i, rdata_a0, rdata_b0, rvalid_a0);
            else pass_cnt++;
        end
    endtask

    // Reset 5 edges into CLEAR; port activity during CLEAR must be ignored.
    task automatic test_reset_mid_clear();
        do_reset(1);
        repeat (5) step();
        total_cnt++; if (init_done0 !== 1'b0) $display("FAIL midclear_init got=%b exp=0", init_done0); else pass_cnt++;
        do_reset(1);
        cs = 1'b0; wr_rd_a = 1'b1; addr_a = 4'd2; wdata_a = 8'h55;
        wr_rd_b = 1'b0; addr_b = 4'd2;
        for (int i = 1; i <= 16; i++) begin
            step();
            total_cnt++;
            if (init_done0 !== (i == 16) || rvalid_b0 !== 1'b0)
                $display("FAIL midclear_timing edge=%0d got init=%b rv=%b exp init=%b rv=0", i, init_done0, rvalid_b0, (i == 16));
            else pass_cnt++;
        end
        set_idle();
        rd(4'd2, 4'd2);
        total_cnt++; if (rdata_a0 !== 8'h00) $display("FAIL clear_ignores_ports got=%h exp=%h", rdata_a0, 8'h00); else pass_cnt++;
    endtask

    task automatic test_chip_select();
        cs = 1'b1; wr_rd_a = 1'b1; addr_a = 4'd3; wdata_a = 8'hAA;
        wr_rd_b = 1'b0; addr_b = 4'd3;
        repeat (LAT) step();
        total_cnt++; if (rvalid_b0 !== 1'b0) $display("FAIL cs_rvalid got=%b exp=0", rvalid_b0); else pass_cnt++;
        set_idle();
        rd(4'd3, 4'd3);
        total_cnt++; if (rdata_b0 !== 8'h00) $display("FAIL cs_write_blocked got=%h exp=%h", rdata_b0, 8'h00); else pass_cnt++;
        total_cnt++; if (rvalid_b0 !== 1'b1) $display("FAIL cs_read_valid got=%b exp=1", rvalid_b0); else pass_cnt++;
    endtask

    task automatic test_write_then_read();
        wr_a(4'd5, 8'h3C);
        cs = 1'b0; wr_rd_a = 1'b0; addr_a = 4'd0; wr_rd_b = 1'b0; addr_b = 4'd5;
        step();
        set_idle();
`ifdef DPR_OUT_REG_EN
        total_cnt++; if (rvalid_b0 !== 1'b0) $display("FAIL lat2_early_valid got=%b exp=0", rvalid_b0); else pass_cnt++;
        step();
`endif
        total_cnt++; if (rdata_b0 !== 8'h3C) $display("FAIL wr_rd_data got=%h exp=%h", rdata_b0, 8'h3C); else pass_cnt++;
        total_cnt++; if (rvalid_b0 !== 1'b1) $display("FAIL wr_rd_valid got=%b exp=1", rvalid_b0); else pass_cnt++;
        step();
        total_cnt++; if (rvalid_b0 !== 1'b0) $display("FAIL valid_one_cycle got=%b exp=0", rvalid_b0); else pass_cnt++;
        total_cnt++; if (rdata_b0 !== 8'h3C) $display("FAIL rdata_hold got=%h exp=%h", rdata_b0, 8'h3C); else pass_cnt++;
    endtask

    task automatic test_read_during_write();
        wr_a(4'd7, 8'h22);
        cs = 1'b0; wr_rd_a = 1'b1; addr_a = 4'd7; wdata_a = 8'h11;
        wr_rd_b = 1'b0; addr_b = 4'd7;
        step();
        total_cnt++; if (collision0 !== 1'b0) $display("FAIL rdw_collision got=%b exp=0", collision0); else pass_cnt++;
        set_idle();
        repeat (LAT - 1) step();
        total_cnt++; if (rdata_b0 !== 8'h22) $display("FAIL rdw_old_data got=%h exp=%h", rdata_b0, 8'h22); else pass_cnt++;
        rd(4'd7, 4'd7);
        total_cnt++; if (rdata_a0 !== 8'h11) $display("FAIL rdw_new_data got=%h exp=%h", rdata_a0, 8'h11); else pass_cnt++;
    endtask

    task automatic test_write_collision();
        cs = 1'b0; wr_rd_a = 1'b1; addr_a = 4'd5; wdata_a = 8'd77;
        wr_rd_b = 1'b1; addr_b = 4'd5; wdata_b = 8'd98;
        step();
        set_idle();
        total_cnt++; if (collision0 !== 1'b1) $display("FAIL coll_pulse_p0 got=%b exp=1", collision0); else pass_cnt++;
        total_cnt++; if (collision1 !== 1'b1) $display("FAIL coll_pulse_p1 got=%b exp=1", collision1); else pass_cnt++;
        step();
        total_cnt++; if (collision0 !== 1'b0) $display("FAIL coll_end_p0 got=%b exp=0", collision0); else pass_cnt++;
        total_cnt++; if (collision1 !== 1'b0) $display("FAIL coll_end_p1 got=%b exp=0", collision1); else pass_cnt++;
        rd(4'd5, 4'd5);
        total_cnt++; if (rdata_a0 !== 8'd77) $display("FAIL coll_winner_p0 got=%0d exp=%0d", rdata_a0, 77); else pass_cnt++;
        total_cnt++; if (rdata_a1 !== 8'd98) $display("FAIL coll_winner_p1 got=%0d exp=%0d", rdata_a1, 98); else pass_cnt++;
        // Different addresses on the same edge: both stored, no collision.
        cs = 1'b0; wr_rd_a = 1'b1; addr_a = 4'd4; wdata_a = 8'h44;
        wr_rd_b = 1'b1; addr_b = 4'd6; wdata_b = 8'h66;
        step();
        set_idle();
        total_cnt++; if (collision0 !== 1'b0) $display("FAIL diff_addr_collision got=%b exp=0", collision0); else pass_cnt++;
        rd(4'd4, 4'd6);
        total_cnt++; if (rdata_a0 !== 8'h44) $display("FAIL diff_addr_a got=%h exp=%h", rdata_a0, 8'h44); else pass_cnt++;
        total_cnt++; if (rdata_b0 !== 8'h66) $display("FAIL diff_addr_b got=%h exp=%h", rdata_b0, 8'h66); else pass_cnt++;
        total_cnt++; if (rdata_a1 !== 8'h44 || rdata_b1 !== 8'h66)
            $display("FAIL diff_addr_p1 got a=%h b=%h exp a=44 b=66", rdata_a1, rdata_b1); else pass_cnt++;
    endtask

    initial begin
        rst_n   = 1'b0;
        cs      = 1'b1;
        wr_rd_a = 1'b0; addr_a = '0; wdata_a = '0;
        wr_rd_b = 1'b0; addr_b = '0; wdata_b = '0;
        step();
        test_reset();
        test_clear_zeroes();
        test_reset_mid_clear();
        test_chip_select();
        test_write_then_read();
        test_read_during_write();
        test_write_collision();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
